pcw_vram_prefetch: RTL and testbench
====================================

Name: pcw_vram_prefetch

Overview:
- Video-side fetch engine that sits directly downstream of the SDRAM controller's VRAM port.
- Walks word addresses for one scanline and drives vram_addr.
- Each word address is held long enough for the controller to detect the change, fetch the word and present vram_dout.
- Captured words go into a small FIFO that the pixel shifter drains one byte at a time.

Parameters:
- WORDS_PER_LINE, 45, 16-bit words fetched per line (90 bytes = 720 mono pixels).
- FIFO_DEPTH, 4, word entries in the output FIFO; power of two.
- WAIT_REFS, 3, clkref rising edges to wait after driving an address before capturing. This covers the controller's request slot plus one slot lost to a CPU access.

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- reset  in  1  asynchronous, active-high reset.
- clkref  in  1  SDRAM slot reference clock; same signal the controller syncs to.
- line_start  in  1  single-cycle pulse that starts fetching a new line.
- line_addr  in  23  byte address of the first word of the line; bit 0 is ignored.
- vram_addr  out  23  byte address to the controller; bit 0 is always 0.
- vram_dout  in  16  word returned by the controller.
- pix_rd  in  1  pops one byte from the output side.
- pix_byte  out  8  current output byte; valid when pix_valid is 1.
- pix_valid  out  1  at least one byte is available.
- busy  out  1  line fetch in progress (words remaining or a fetch in flight).
- underrun  out  1  sticky flag: pix_rd seen while pix_valid was 0; cleared by line_start.

Behaviour:
- Reset (asynchronous, all outputs):
  - vram_addr = 23'h7FFFFE, pix_byte = 0, pix_valid = 0, busy = 0, underrun = 0.
  - FIFO empty, remaining = 0, FSM in IDLE.
  - Software must not start the first line at 23'h7FFFFE, because the controller only refetches when address bits [15:1] change.
- clkref edge detect: clkref is registered; ref_rise = ~clkref_q & clkref.
- Fetch FSM (one fetch in flight at most):
  - IDLE: if remaining != 0 and fifo_count < FIFO_DEPTH, go to ISSUE.
  - ISSUE (1 cycle): vram_addr <= {ptr, 1'b0}; wcnt <= WAIT_REFS; go to WAIT.
  - WAIT: wcnt decrements on each ref_rise. When wcnt == 0, go to CAPTURE.
  - CAPTURE (1 cycle): push vram_dout; ptr <= ptr + 1; remaining <= remaining - 1; go to IDLE.
- ptr is a 22-bit word pointer and wraps modulo 2^22; vram_addr bit 0 is always 0.
- The FIFO-space check in IDLE guarantees the CAPTURE push never overflows.
- line_start (any state, highest priority):
  - FIFO flushed, byte phase reset, underrun cleared.
  - ptr <= line_addr[22:1], remaining <= WORDS_PER_LINE, FSM -> IDLE.
  - Any in-flight fetch is discarded and not pushed.
- busy = (remaining != 0) | (FSM != IDLE).
- Output side:
  - The head word is emitted low byte first: [7:0], then [15:8]. A phase bit selects the byte.
  - pix_byte is combinational from the FIFO head and phase.
  - pix_valid = (fifo_count != 0).
  - pix_rd with pix_valid toggles phase; on the high-byte pop the head word is also popped.
  - pix_rd with pix_valid = 0: no state change, underrun <= 1, pix_byte stays 0x00 (empty FIFO forces 0x00).
- Simultaneous push (CAPTURE) and pop in the same cycle are both honoured; fifo_count is unchanged.
- Throughput: 1 word per (WAIT_REFS + ~1) clkref periods. At 8 clk per clkref and WAIT_REFS = 3, that is about 4 clkref periods per word. The line must be started early enough that the shifter never starves.

Test Plan:
1. Reset line: assert reset mid-WAIT → all outputs at reset values immediately (asynchronous); after release, no vram_addr change until line_start.
2. Single line: line_start with line_addr=23'h001000 → vram_addr steps 0x1000, 0x1002, … 0x1058 (45 words). Each word is captured 3 ref_rise edges after its ISSUE. busy drops after the 45th capture.
3. Byte order: model returns 16'hA55A at 0x1000 → pix_byte = 8'h5A, then 8'hA5 after one pix_rd; the word pops on the second pix_rd.
4. FIFO full: never assert pix_rd → exactly 4 fetches issue, then vram_addr holds. One 2-byte drain lets the 5th fetch issue.
5. Underrun: pix_rd while empty → underrun = 1 and pix_byte = 0x00, no pointer change. The next line_start clears underrun.
6. Restart mid-line: line_start at 0x2000 during WAIT of word 10 of a previous line → FIFO empty next cycle, the old word is not pushed, and the first new vram_addr is 0x2000.

Source files
------------

// File: rtl/pcw_vram_prefetch.sv
// rtl/pcw_vram_prefetch.sv - scanline VRAM word fetcher feeding a byte-wide pixel FIFO
// One fetch in flight at a time; each address is held for WAIT_REFS clkref edges before capture.
module pcw_vram_prefetch #(
  parameter int WORDS_PER_LINE = 45,
  parameter int FIFO_DEPTH     = 4,
  parameter int WAIT_REFS      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkref,
  input  logic        line_start,
  input  logic [22:0] line_addr,
  output logic [22:0] vram_addr,
  input  logic [15:0] vram_dout,
  input  logic        pix_rd,
  output logic [7:0]  pix_byte,
  output logic        pix_valid,
  output logic        busy,
  output logic        underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(WORDS_PER_LINE + 1);
  localparam int WW = $clog2(WAIT_REFS + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] LINE_WORDS = RW'(WORDS_PER_LINE);
  localparam logic [WW-1:0] WAIT_C     = WW'(WAIT_REFS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          clkref_q, clkref_d;
  logic [21:0]   ptr_q, ptr_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [22:0]   vram_addr_q, vram_addr_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;
  logic          underrun_q, underrun_d;

  logic          ref_rise;
  logic          valid;
  logic          rd_ok;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = line_addr[0];

  always_comb begin
    clkref_d    = clkref;
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    wcnt_d      = wcnt_q;
    vram_addr_d = vram_addr_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    phase_d     = phase_q;
    underrun_d  = underrun_q;
    push        = 1'b0;

    ref_rise = clkref & ~clkref_q;
    valid    = (count_q != '0);
    rd_ok    = pix_rd & valid;
    pop      = rd_ok & phase_q;

    case (state_q)
      ST_IDLE: begin
        if (remaining_q != '0 && count_q < DEPTH_C) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        vram_addr_d = {ptr_q, 1'b0};
        wcnt_d      = WAIT_C;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_CAPTURE;
        else if (ref_rise) wcnt_d = wcnt_q - WW'(1);
      end
      ST_CAPTURE: begin
        push        = 1'b1;
        ptr_d       = ptr_q + 22'd1;
        remaining_d = remaining_q - RW'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Space was checked before ISSUE, so a CAPTURE push always has room.
    if (push) begin
      mem_d[wr_ptr_q] = vram_dout;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (rd_ok) phase_d = ~phase_q;
    if (pix_rd && !valid) underrun_d = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new line abandons everything, including a fetch already in flight.
    if (line_start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      phase_d     = 1'b0;
      underrun_d  = 1'b0;
      ptr_d       = line_addr[22:1];
      remaining_d = LINE_WORDS;
      vram_addr_d = vram_addr_q;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clkref_q    <= 1'b0;
      ptr_q       <= '0;
      remaining_q <= '0;
      wcnt_q      <= '0;
      vram_addr_q <= 23'h7FFFFE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      phase_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clkref_q    <= clkref_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      wcnt_q      <= wcnt_d;
      vram_addr_q <= vram_addr_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      underrun_q  <= underrun_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign pix_valid = valid;
  assign pix_byte  = !valid ? 8'h00 : (phase_q ? head[15:8] : head[7:0]);
  assign vram_addr = vram_addr_q;
  assign busy      = (remaining_q != '0) | (state_q != ST_IDLE);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_pcw_vram_prefetch.sv
// tb/tb_pcw_vram_prefetch.sv - directed self-checking bench for pcw_vram_prefetch
// Memory model: 0x1000 holds A55A; every other word is {~b, b}, b = addr[8:1] ^ addr[16:9].
module tb_pcw_vram_prefetch;

  logic        clk;
  logic        reset;
  logic        clkref;
  logic        line_start;
  logic [22:0] line_addr;
  logic [22:0] vram_addr;
  logic [15:0] vram_dout;
  logic        pix_rd;
  logic [7:0]  pix_byte;
  logic        pix_valid;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  pcw_vram_prefetch dut (
    .clk        (clk),
    .reset      (reset),
    .clkref     (clkref),
    .line_start (line_start),
    .line_addr  (line_addr),
    .vram_addr  (vram_addr),
    .vram_dout  (vram_dout),
    .pix_rd     (pix_rd),
    .pix_byte   (pix_byte),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .underrun   (underrun)
  );

  function automatic logic [15:0] model(input logic [22:0] a);
    logic [7:0] b;
    b = a[8:1] ^ a[16:9];
    if (a == 23'h001000) return 16'hA55A;
    return {~b, b};
  endfunction

  assign vram_dout = model(vram_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8 clk per clkref, edges offset from both clk edges
  initial begin
    clkref = 1'b0;
    #2;
    forever #40 clkref = ~clkref;
  end

  task automatic pulse_start(input logic [22:0] a);
    @(negedge clk);
    line_addr  = a;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; line_start = 1'b0; line_addr = '0; pix_rd = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vram_addr !== 23'h7FFFFE) begin errors++; $display("FAIL reset_vram_addr: got %h expected 7ffffe", vram_addr); end
    checks++; if (pix_byte !== 8'h00) begin errors++; $display("FAIL reset_pix_byte: got %h expected 00", pix_byte); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    int moved;
    seen = 0; moved = 0;
    pulse_start(23'h005000);
    for (int n = 0; n < 100 && !seen; n++) begin
      if (vram_addr === 23'h005000) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmw_issue: got %h expected 005000", vram_addr); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_busy_before: got %b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (vram_addr !== 23'h7FFFFE) begin errors++; $display("FAIL rmw_vram_addr: got %h expected 7ffffe", vram_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b expected 0", busy); end
    checks++; if (pix_valid !== 1'b0 || pix_byte !== 8'h00 || underrun !== 1'b0) begin
      errors++; $display("FAIL rmw_outputs: got valid=%b byte=%h underrun=%b expected 0 00 0", pix_valid, pix_byte, underrun);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (vram_addr !== 23'h7FFFFE || busy !== 1'b0) moved++;
    end
    checks++; if (moved != 0) begin errors++; $display("FAIL rmw_idle_after: got %0d active cycles expected 0", moved); end
  endtask

  task automatic test_single_line;
    logic [22:0] prev;
    logic [15:0] w;
    logic [7:0]  eb;
    logic        prev_ref;
    int n_addr, nbytes, refs, bad_gap, bad_addr, bad_byte, moved;
    bit done;
    n_addr = 0; nbytes = 0; refs = 0; bad_gap = 0; bad_addr = 0; bad_byte = 0; moved = 0; done = 0;
    pix_rd = 1'b0;
    prev = vram_addr;
    pulse_start(23'h001000);
    prev_ref = clkref;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (vram_addr !== prev) begin
        if (vram_addr !== 23'h001000 + 23'(2 * n_addr)) bad_addr++;
        if (n_addr > 0 && refs != 3) bad_gap++;
        n_addr++; refs = 0; prev = vram_addr;
      end else if (clkref && !prev_ref) refs++;
      prev_ref = clkref;
      if (pix_valid) begin
        w  = model(23'h001000 + 23'(2 * (nbytes / 2)));
        eb = (nbytes % 2 == 1) ? w[15:8] : w[7:0];
        if (pix_byte !== eb) bad_byte++;
        nbytes++;
        pix_rd = 1'b1;
      end else begin
        pix_rd = 1'b0;
      end
      if (!busy && !pix_valid && n_addr > 0) done = 1;
    end
    pix_rd = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL line_done: got busy=%b after cycle budget expected 0", busy); end
    checks++; if (n_addr != 45) begin errors++; $display("FAIL line_words: got %0d expected 45", n_addr); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL line_addr_seq: got %0d bad addresses expected 0", bad_addr); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL line_ref_gap: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (bad_byte != 0 || nbytes != 90) begin errors++; $display("FAIL line_bytes: got %0d bytes %0d bad expected 90 0", nbytes, bad_byte); end
    checks++; if (vram_addr !== 23'h001058) begin errors++; $display("FAIL line_last_addr: got %h expected 001058", vram_addr); end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (vram_addr !== 23'h001058 || busy !== 1'b0) moved++;
    end
    checks++; if (moved != 0) begin errors++; $display("FAIL line_stops: got %0d active cycles expected 0", moved); end
  endtask

  task automatic test_byte_order;
    bit seen;
    seen = 0;
    pix_rd = 1'b0;
    pulse_start(23'h001000);
    for (int n = 0; n < 200 && !seen; n++) begin
      if (pix_valid === 1'b1) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL bo_valid: got %b expected 1", pix_valid); end
    checks++; if (pix_byte !== 8'h5A) begin errors++; $display("FAIL bo_low: got %h expected 5a", pix_byte); end
    pix_rd = 1'b1; @(negedge clk); pix_rd = 1'b0;
    checks++; if (pix_byte !== 8'hA5 || pix_valid !== 1'b1) begin errors++; $display("FAIL bo_high: got %h valid=%b expected a5 1", pix_byte, pix_valid); end
    pix_rd = 1'b1; @(negedge clk); pix_rd = 1'b0;
    checks++; if (pix_valid !== 1'b0 || pix_byte !== 8'h00) begin errors++; $display("FAIL bo_pop: got valid=%b byte=%h expected 0 00", pix_valid, pix_byte); end
  endtask

  task automatic test_fifo_full;
    logic [22:0] prev;
    int n_addr;
    bit seen;
    n_addr = 0; seen = 0;
    pix_rd = 1'b0;
    prev = vram_addr;
    pulse_start(23'h003000);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (vram_addr !== prev) begin n_addr++; prev = vram_addr; end
    end
    checks++; if (n_addr != 4) begin errors++; $display("FAIL full_issues: got %0d expected 4", n_addr); end
    checks++; if (vram_addr !== 23'h003006 || busy !== 1'b1) begin errors++; $display("FAIL full_hold: got %h busy=%b expected 003006 1", vram_addr, busy); end
    checks++; if (pix_byte !== 8'h18) begin errors++; $display("FAIL full_head_low: got %h expected 18", pix_byte); end
    pix_rd = 1'b1; @(negedge clk);
    checks++; if (pix_byte !== 8'hE7) begin errors++; $display("FAIL full_head_high: got %h expected e7", pix_byte); end
    @(negedge clk); pix_rd = 1'b0;
    checks++; if (pix_byte !== 8'h19) begin errors++; $display("FAIL full_next_head: got %h expected 19", pix_byte); end
    for (int n = 0; n < 100 && !seen; n++) begin
      if (vram_addr === 23'h003008) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL full_fifth_issue: got %h expected 003008", vram_addr); end
  endtask

  task automatic test_underrun;
    bit seen;
    seen = 0;
    pix_rd = 1'b0;
    pulse_start(23'h006000);
    pix_rd = 1'b1; @(negedge clk); pix_rd = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b expected 1", underrun); end
    checks++; if (pix_byte !== 8'h00 || pix_valid !== 1'b0) begin errors++; $display("FAIL ur_empty: got byte=%h valid=%b expected 00 0", pix_byte, pix_valid); end
    for (int n = 0; n < 200 && !seen; n++) begin
      if (pix_valid === 1'b1) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen || pix_byte !== 8'h30) begin errors++; $display("FAIL ur_first_byte: got %h valid=%b expected 30 1", pix_byte, pix_valid); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
    pulse_start(23'h006100);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
  endtask

  task automatic test_restart_mid_line;
    logic [22:0] prev;
    bit seen;
    seen = 0;
    pix_rd = 1'b0;
    pulse_start(23'h004000);
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (vram_addr === 23'h004010) seen = 1;
      pix_rd = pix_valid & ~seen;
    end
    pix_rd = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL rs_reach_word9: got %h expected 004010", vram_addr); end
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (vram_addr === 23'h004012) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rs_reach_word10: got %h expected 004012", vram_addr); end
    repeat (6) @(negedge clk);
    checks++; if (pix_valid !== 1'b1 || pix_byte !== 8'h28) begin errors++; $display("FAIL rs_before: got byte=%h valid=%b expected 28 1", pix_byte, pix_valid); end
    prev = vram_addr;
    pulse_start(23'h002000);
    checks++; if (pix_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rs_flush: got valid=%b busy=%b expected 0 1", pix_valid, busy); end
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (vram_addr !== prev) seen = 1; else @(negedge clk);
    end
    checks++; if (vram_addr !== 23'h002000) begin errors++; $display("FAIL rs_first_addr: got %h expected 002000", vram_addr); end
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (pix_valid === 1'b1) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen || pix_byte !== 8'h10) begin errors++; $display("FAIL rs_first_byte: got %h valid=%b expected 10 1", pix_byte, pix_valid); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_single_line();
    test_byte_order();
    test_fifo_full();
    test_underrun();
    test_restart_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
